scarv_cop_palu_pmul_seq: RTL and testbench

//  Parametrised sequential packed multiplier for the COP PALU; successor to the single-width shift-and-add unit.

---
 rtl/scarv_cop_palu_pmul_seq_pkg.sv | 127 ++++++++++++
 rtl/scarv_cop_pmul_lane_step.sv | 55 +++++
 rtl/scarv_cop_palu_pmul_seq.sv | 168 ++++++++++++++++
 tb/tb_scarv_cop_palu_pmul_seq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scarv_cop_palu_pmul_seq_pkg.sv
// Shared definitions for the COP PALU sequential packed multiplier.
// Holds the pack-width encodings, FSM state type and lane helper functions.
// The accumulator is 2*XLEN (64) bits wide. Each lane of width LW owns a
// 2*LW-bit segment of it. All helpers work segment-locally, so no bit or
// carry ever moves from one lane into the next.
package scarv_cop_palu_pmul_seq_pkg;

    typedef enum logic [2:0] {
        PW_32 = 3'd0,
        PW_16 = 3'd1,
        PW_8  = 3'd2,
        PW_4  = 3'd3,
        PW_2  = 3'd4
    } pw_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    localparam logic [63:0] ACC_ONE = 64'd1;

    // log2 of the lane width. Reserved encodings time like 32-bit lanes.
    function automatic int unsigned lane_log2(input logic [2:0] pw);
        case (pw)
            PW_32:   return 5;
            PW_16:   return 4;
            PW_8:    return 3;
            PW_4:    return 2;
            PW_2:    return 1;
            default: return 5;
        endcase
    endfunction

    function automatic logic pw_reserved(input logic [2:0] pw);
        return pw > 3'd4;
    endfunction

    function automatic int unsigned run_cycles(input int unsigned lg, input int unsigned bpc);
        int unsigned lw;
        lw = 32'd1 << lg;
        return (lw >= bpc) ? lw / bpc : 32'd1;
    endfunction

    // Marks the top bit of every 2*LW segment.
    function automatic logic [63:0] seg_msb_mask(input int unsigned lg);
        logic [63:0] m;
        int unsigned segm;
        m    = '0;
        segm = (32'd2 << lg) - 32'd1;
        for (int unsigned i = 0; i < 64; i++)
            if ((i & segm) == segm) m |= ACC_ONE << i;
        return m;
    endfunction

    // Left shift inside each segment. Bits that would cross into the next
    // segment are dropped.
    function automatic logic [63:0] seg_shl(input logic [63:0] x, input int unsigned k,
                                            input int unsigned lg);
        logic [63:0] keep;
        int unsigned segm;
        keep = '0;
        segm = (32'd2 << lg) - 32'd1;
        for (int unsigned i = 0; i < 64; i++)
            if ((i & segm) >= k) keep |= ACC_ONE << i;
        return (x << k) & keep;
    endfunction

    // Segment-wise add. The segment MSBs are summed by XOR, so a carry out of
    // one segment never reaches the next.
    function automatic logic [63:0] lane_add(input logic [63:0] x, input logic [63:0] y,
                                             input logic [63:0] msb);
        return ((x & ~msb) + (y & ~msb)) ^ ((x ^ y) & msb);
    endfunction

    // Places each LW-bit lane of a into the low half of its 2*LW segment.
    function automatic logic [63:0] expand_lanes(input logic [31:0] a, input int unsigned lg);
        logic [63:0] r;
        logic [31:0] t;
        int unsigned lw;
        int unsigned pos;
        r  = '0;
        lw = 32'd1 << lg;
        for (int unsigned i = 0; i < 64; i++) begin
            pos = i & ((lw << 1) - 32'd1);
            if (pos < lw) begin
                t = a >> ((i >> (lg + 32'd1)) * lw + pos);
                if (t[0]) r |= ACC_ONE << i;
            end
        end
        return r;
    endfunction

    // Right shift inside each LW-bit lane. Zeros are shifted in at the lane top.
    function automatic logic [31:0] lane_shr(input logic [31:0] b, input int unsigned n,
                                             input int unsigned lg);
        logic [31:0] r;
        logic [31:0] t;
        int unsigned lw;
        r  = '0;
        lw = 32'd1 << lg;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((i & (lw - 32'd1)) + n < lw) begin
                t = b >> (i + n);
                if (t[0]) r |= 32'd1 << i;
            end
        end
        return r;
    endfunction

    // Gathers the low or high LW bits of every segment into a packed result.
    function automatic logic [31:0] pick_half(input logic [63:0] acc, input int unsigned lg,
                                              input logic hi);
        logic [31:0] r;
        logic [63:0] t;
        int unsigned lw;
        r  = '0;
        lw = 32'd1 << lg;
        for (int unsigned i = 0; i < 32; i++) begin
            t = acc >> ((i >> lg) * (lw << 1) + (i & (lw - 32'd1)) + (hi ? lw : 32'd0));
            if (t[0]) r |= 32'd1 << i;
        end
        return r;
    endfunction

endpackage

// File: rtl/scarv_cop_pmul_lane_step.sv
// One combinational multiply step over all lanes.
// Ports:
//   acc_i    : 2*XLEN accumulator, one 2*LW segment per lane
//   a_i      : multiplicand, lane-expanded and already shifted for this step
//   b_i      : multiplier. Bits [BPC-1:0] of each lane are this step's bits.
//   pw_i     : pack width encoding
//   ncarry_i : 1 = XOR accumulate (carry-less), 0 = integer add
//   acc_o    : accumulator after retiring BPC multiplier bits
module scarv_cop_pmul_lane_step
    import scarv_cop_palu_pmul_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPC  = 1
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [2*XLEN-1:0] a_i,
    input  logic [XLEN-1:0]   b_i,
    input  logic [2:0]        pw_i,
    input  logic              ncarry_i,
    output logic [2*XLEN-1:0] acc_o
);

    int unsigned       lg;
    int unsigned       lw;
    logic [2*XLEN-1:0] msb;
    logic [2*XLEN-1:0] sum;
    logic [2*XLEN-1:0] part;
    logic [2*XLEN-1:0] sel;
    logic [XLEN-1:0]   bsh;

    always_comb begin
        lg   = lane_log2(pw_i);
        lw   = 32'd1 << lg;
        msb  = seg_msb_mask(lg);
        sum  = acc_i;
        part = '0;
        sel  = '0;
        bsh  = '0;
        for (int unsigned k = 0; k < BPC; k++) begin
            // Multiplier bits at or above LW do not exist inside a lane.
            if (k < lw) begin
                part = seg_shl(a_i, k, lg);
                sel  = '0;
                for (int unsigned i = 0; i < 2*XLEN; i++) begin
                    bsh = b_i >> ((i >> (lg + 32'd1)) * lw + k);
                    if (bsh[0]) sel |= ACC_ONE << i;
                end
                part = part & sel;
                sum  = ncarry_i ? (sum ^ part) : lane_add(sum, part, msb);
            end
        end
        acc_o = sum;
    end

endmodule

// File: rtl/scarv_cop_palu_pmul_seq.sv
// Sequential packed multiplier for the COP PALU.
// It computes a*b in each lane, with integer or carry-less arithmetic, and
// returns the low or high half of each 2*LW product. Each RUN cycle retires
// BPC multiplier bits.
// Ports:
//   g_clk, g_reset       : clock and synchronous active-high reset
//   req_valid/req_ready  : request handshake. req_ready is high only in IDLE.
//   a, b                 : packed multiplicand and multiplier
//   pw                   : pack width (0=32,1=16,2=8,3=4,4=2; 5-7 reserved)
//   high                 : select the high half of each lane product
//   ncarry               : carry-less multiply
//   flush                : abort the in-flight operation
//   rsp_valid/rsp_ready  : response handshake
//   result, err          : packed result. err flags a reserved pw.
module scarv_cop_palu_pmul_seq
    import scarv_cop_palu_pmul_seq_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPC  = 1
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      pw,
    input  logic            high,
    input  logic            ncarry,
    input  logic            flush,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] result,
    output logic            err
);

    state_e            state_q;
    logic [5:0]        ctr_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              err_q;
    logic [XLEN-1:0]   result_q;

    logic [2*XLEN-1:0] acc_q,  acc_d;
    logic [2*XLEN-1:0] a_q,    a_d;
    logic [XLEN-1:0]   b_q,    b_d;
    logic [2:0]        pw_q,   pw_d;
    logic              high_q, high_d;
    logic              ncarry_q, ncarry_d;

    logic [2*XLEN-1:0] acc_step;
    int unsigned       lg_q;
    int unsigned       cycles_q;
    logic              accept;
    logic              last_step;

    scarv_cop_pmul_lane_step #(
        .XLEN (XLEN),
        .BPC  (BPC)
    ) u_step (
        .acc_i    (acc_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .pw_i     (pw_q),
        .ncarry_i (ncarry_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        lg_q      = lane_log2(pw_q);
        cycles_q  = run_cycles(lg_q, BPC);
        accept    = req_valid && req_ready_q && !flush;
        last_step = (32'(ctr_q) == cycles_q - 32'd1);
    end

    // Operand and accumulator next state. The multiplicand moves up by BPC and
    // the multiplier moves down by BPC each step. This keeps the step logic
    // independent of ctr.
    always_comb begin
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        pw_d     = pw_q;
        high_d   = high_q;
        ncarry_d = ncarry_q;
        if (accept) begin
            acc_d    = '0;
            a_d      = expand_lanes(a, lane_log2(pw));
            b_d      = b;
            pw_d     = pw;
            high_d   = high;
            ncarry_d = ncarry;
        end else if (state_q == ST_RUN && !flush) begin
            acc_d = acc_step;
            a_d   = seg_shl(a_q, BPC, lg_q);
            b_d   = lane_shr(b_q, BPC, lg_q);
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            pw_q     <= '0;
            high_q   <= 1'b0;
            ncarry_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pw_q     <= pw_d;
            high_q   <= high_d;
            ncarry_q <= ncarry_d;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge g_clk) begin
        if (g_reset || flush) begin
            state_q     <= ST_IDLE;
            ctr_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_RUN;
                        ctr_q       <= '0;
                        req_ready_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (last_step) begin
                        state_q     <= ST_DONE;
                        ctr_q       <= '0;
                        rsp_valid_q <= 1'b1;
                        err_q       <= pw_reserved(pw_q);
                        result_q    <= pw_reserved(pw_q) ? '0 : pick_half(acc_step, lg_q, high_q);
                    end else begin
                        ctr_q <= ctr_q + 6'd1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign result    = result_q;
    assign err       = err_q;

endmodule

// File: tb/tb_scarv_cop_palu_pmul_seq.sv
// Bench for scarv_cop_palu_pmul_seq. Three instances with BPC = 1, 2 and 4
// share the same stimulus. Each is checked against a per-lane arithmetic
// reference model.
module tb_scarv_cop_palu_pmul_seq;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] a, b;
    logic [2:0]  pw;
    logic        high, ncarry;
    logic        req_valid, rsp_ready;

    logic        req_ready [NI];
    logic        rsp_valid [NI];
    logic        err       [NI];
    logic [31:0] result    [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        scarv_cop_palu_pmul_seq #(
            .XLEN (32),
            .BPC  (1 << g)
        ) u_dut (
            .g_clk     (clk),
            .g_reset   (rst),
            .req_valid (req_valid),
            .req_ready (req_ready[g]),
            .a         (a),
            .b         (b),
            .pw        (pw),
            .high      (high),
            .ncarry    (ncarry),
            .flush     (flush),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready),
            .result    (result[g]),
            .err       (err[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: slice each lane out and multiply it as an ordinary integer
    // (or as a GF(2) polynomial).
    function automatic logic [31:0] ref_mul(input logic [31:0] ma, input logic [31:0] mb,
                                            input logic [2:0] mpw, input logic mh, input logic mn);
        longint unsigned av, bv, p, h, mask;
        int lw;
        logic [31:0] r;
        if (mpw > 3'd4) return 32'd0;
        lw   = 32 >> mpw;
        mask = (64'd1 << lw) - 64'd1;
        r    = '0;
        for (int l = 0; l < 32 / lw; l++) begin
            av = (64'(ma) >> (l * lw)) & mask;
            bv = (64'(mb) >> (l * lw)) & mask;
            if (mn) begin
                p = 0;
                for (int j = 0; j < lw; j++)
                    if (((bv >> j) & 64'd1) != 0) p = p ^ (av << j);
            end else begin
                p = av * bv;
            end
            h = mh ? ((p >> lw) & mask) : (p & mask);
            r = r | 32'(h << (l * lw));
        end
        return r;
    endfunction

    function automatic int exp_latency(input logic [2:0] mpw, input int bpc);
        int lw;
        lw = (mpw > 3'd4) ? 32 : (32 >> mpw);
        return ((lw >= bpc) ? lw / bpc : 1) + 1;
    endfunction

    function automatic logic all_ready();
        return req_ready[0] && req_ready[1] && req_ready[2];
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!all_ready() && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/ready"}, 64'(all_ready()), 64'd1);
    endtask

    task automatic run_txn(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                           input logic [2:0] tpw, input logic th, input logic tn,
                           input logic [31:0] exp_r);
        int          lat   [NI];
        bit          seen  [NI];
        logic [31:0] got_r [NI];
        logic        got_e [NI];
        wait_ready(tag);
        @(negedge clk);
        a = ta; b = tb_; pw = tpw; high = th; ncarry = tn;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // Inputs changing after acceptance must have no effect.
        a = $urandom; b = $urandom; pw = 3'($urandom_range(0, 7));
        high = ~th; ncarry = ~tn;
        for (int d = 0; d < NI; d++) begin
            seen[d] = 1'b0; lat[d] = 0; got_r[d] = '0; got_e[d] = 1'b0;
        end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < NI; d++) begin
                if (!seen[d] && rsp_valid[d]) begin
                    seen[d]  = 1'b1;
                    lat[d]   = k + 1;
                    got_r[d] = result[d];
                    got_e[d] = err[d];
                end
            end
        end
        for (int d = 0; d < NI; d++) begin
            chk($sformatf("%s/bpc%0d/lat", tag, 1 << d), 64'(lat[d]), 64'(exp_latency(tpw, 1 << d)));
            chk($sformatf("%s/bpc%0d/res", tag, 1 << d), 64'(got_r[d]), 64'(exp_r));
            chk($sformatf("%s/bpc%0d/err", tag, 1 << d), 64'(got_e[d]), 64'(tpw > 3'd4));
        end
    endtask

    task automatic abort_test(input string tag, input bit use_reset);
        int late;
        wait_ready(tag);
        @(negedge clk);
        a = $urandom; b = $urandom; pw = 3'd0; high = 1'b0; ncarry = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        if (use_reset) rst = 1'b1; else flush = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < NI; d++) begin
            chk($sformatf("%s/bpc%0d/rdy", tag, 1 << d), 64'(req_ready[d]), 64'd1);
            chk($sformatf("%s/bpc%0d/vld", tag, 1 << d), 64'(rsp_valid[d]), 64'd0);
        end
        // A request presented together with the abort is not accepted.
        @(negedge clk);
        req_valid = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < NI; d++)
            chk($sformatf("%s/bpc%0d/noacc", tag, 1 << d), 64'(req_ready[d]), 64'd1);
        @(negedge clk);
        req_valid = 1'b0; rst = 1'b0; flush = 1'b0;
        late = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < NI; d++) if (rsp_valid[d]) late++;
        end
        chk({tag, "/norsp"}, 64'(late), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, hold_exp;
        logic [2:0]  rpw;
        logic        rh, rn;
        bit          all_v;
        int          n;

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        a = '0; b = '0; pw = '0; high = 1'b0; ncarry = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < NI; d++) begin
            chk($sformatf("reset/bpc%0d/rdy", 1 << d), 64'(req_ready[d]), 64'd1);
            chk($sformatf("reset/bpc%0d/vld", 1 << d), 64'(rsp_valid[d]), 64'd0);
            chk($sformatf("reset/bpc%0d/res", 1 << d), 64'(result[d]), 64'd0);
            chk($sformatf("reset/bpc%0d/err", 1 << d), 64'(err[d]), 64'd0);
        end

        run_txn("t1_lo", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b0, 1'b0, 32'h00000001);
        run_txn("t1_hi", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b0, 32'hFFFFFFFE);
        run_txn("t2_lo", 32'h02030405, 32'h10101010, 3'd2, 1'b0, 1'b0, 32'h20304050);
        run_txn("t2_hi", 32'h02030405, 32'h10101010, 3'd2, 1'b1, 1'b0, 32'h00000000);
        run_txn("t3_cl", 32'h00000003, 32'h00000003, 3'd0, 1'b0, 1'b1, 32'h00000005);
        run_txn("t3_in", 32'h00000003, 32'h00000003, 3'd0, 1'b0, 1'b0, 32'h00000009);
        run_txn("t4_hi", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 1'b1, 1'b0, 32'hAAAAAAAA);
        run_txn("t4_lo", 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 1'b0, 1'b0, 32'h55555555);
        run_txn("pw5",   32'h12345678, 32'h9ABCDEF0, 3'd5, 1'b0, 1'b0, 32'h00000000);
        run_txn("pw7",   32'hFFFFFFFF, 32'hFFFFFFFF, 3'd7, 1'b1, 1'b1, 32'h00000000);

        // Back-pressure: the result is held while rsp_ready stays low.
        wait_ready("hold");
        ra = $urandom; rb = $urandom;
        hold_exp = ref_mul(ra, rb, 3'd1, 1'b1, 1'b0);
        @(negedge clk);
        a = ra; b = rb; pw = 3'd1; high = 1'b1; ncarry = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        all_v = 1'b0;
        while (!all_v && n < 40) begin
            @(posedge clk); #1;
            n++;
            all_v = rsp_valid[0] && rsp_valid[1] && rsp_valid[2];
        end
        chk("hold/allvld", 64'(all_v), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < NI; d++) begin
                chk($sformatf("hold%0d/bpc%0d/vld", c, 1 << d), 64'(rsp_valid[d]), 64'd1);
                chk($sformatf("hold%0d/bpc%0d/res", c, 1 << d), 64'(result[d]), 64'(hold_exp));
                chk($sformatf("hold%0d/bpc%0d/rdy", c, 1 << d), 64'(req_ready[d]), 64'd0);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < NI; d++) begin
            chk($sformatf("hold_rel/bpc%0d/vld", 1 << d), 64'(rsp_valid[d]), 64'd0);
            chk($sformatf("hold_rel/bpc%0d/rdy", 1 << d), 64'(req_ready[d]), 64'd1);
        end

        abort_test("flush", 1'b0);
        run_txn("post_flush", 32'hDEADBEEF, 32'h0BADF00D, 3'd0, 1'b1, 1'b0,
                ref_mul(32'hDEADBEEF, 32'h0BADF00D, 3'd0, 1'b1, 1'b0));
        abort_test("reset", 1'b1);
        run_txn("post_reset", 32'hCAFEF00D, 32'h13579BDF, 3'd2, 1'b0, 1'b1,
                ref_mul(32'hCAFEF00D, 32'h13579BDF, 3'd2, 1'b0, 1'b1));

        for (int t = 0; t < 40; t++) begin
            ra  = $urandom;
            rb  = $urandom;
            rpw = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            rh  = 1'($urandom_range(0, 1));
            rn  = 1'($urandom_range(0, 1));
            run_txn($sformatf("rnd%0d", t), ra, rb, rpw, rh, rn, ref_mul(ra, rb, rpw, rh, rn));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
